// File: rtl/dm_unit_pkg.sv
// dm_unit_pkg: memory geometry, access-type codes and decode helpers for the data memory stage
package dm_unit_pkg;
  localparam int DEPTH_WORDS = 3072;
  localparam int ADDR_W = 12;
  typedef enum logic [2:0] {
    DM_W  = 3'b000,
    DM_H  = 3'b001,
    DM_B  = 3'b010,
    DM_HU = 3'b011,
    DM_BU = 3'b100
  } dm_sel_e;
  function automatic logic is_half(input logic [2:0] s);
    return s == DM_H || s == DM_HU;
  endfunction
  function automatic logic is_byte(input logic [2:0] s);
    return s == DM_B || s == DM_BU;
  endfunction
  function automatic logic is_known(input logic [2:0] s);
    return s <= DM_BU;
  endfunction
endpackage

// File: rtl/dm_unit_if.sv
// dm_unit_if: datapath-to-data-memory access bus
interface dm_unit_if;
  logic [31:0] pc;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        DWE;
  logic [2:0]  DMSel;
  logic [31:0] rdata;
  modport master (output pc, addr, wdata, DWE, DMSel, input rdata);
  modport slave  (input pc, addr, wdata, DWE, DMSel, output rdata);
endinterface

// File: rtl/dm_unit_load_ext.sv
// dm_load_ext: selects the addressed byte/half of a raw word and sign- or zero-extends it
module dm_load_ext
  import dm_unit_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  sel_i,
  output logic [31:0] rdata_o
);
  logic [7:0]  b;
  logic [15:0] h;
  // lane pick then extension; reserved codes pass the raw word through
  always_comb begin
    b = raw_i[{lane_i, 3'b000} +: 8];
    h = lane_i[1] ? raw_i[31:16] : raw_i[15:0];
    rdata_o = sel_i == DM_H  ? {{16{h[15]}}, h} :
              sel_i == DM_B  ? {{24{b[7]}}, b} :
              sel_i == DM_HU ? {16'h0, h} :
              sel_i == DM_BU ? {24'h0, b} : raw_i;
  end
endmodule

// File: rtl/dm_unit.sv
// dm_unit: data memory with lane-merging stores and extended loads; DM_DISPLAY_EN logs committed stores
module dm_unit
  import dm_unit_pkg::*;
(
  input logic clk,
  input logic reset,
  dm_unit_if.slave bus
);
  logic [31:0]       mem_q [DEPTH_WORDS];
  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic              wr_en;
  logic [31:0]       raw;
  logic [31:0]       merged_d;
  assign idx      = bus.addr[ADDR_W+1:2];
  assign in_range = bus.addr < 32'(4 * DEPTH_WORDS);
  assign raw      = in_range ? mem_q[idx] : '0;
  // merge the store lane(s) into the current word; other bytes keep their old value
  always_comb begin
    wr_en    = bus.DWE && in_range && is_known(bus.DMSel);
    merged_d = bus.DMSel == DM_W ? bus.wdata : raw;
    if (is_half(bus.DMSel)) merged_d[{bus.addr[1], 4'b0000} +: 16] = bus.wdata[15:0];
    if (is_byte(bus.DMSel)) merged_d[{bus.addr[1:0], 3'b000} +: 8] = bus.wdata[7:0];
  end
  // whole-array clear on reset takes priority over any store in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[idx] <= merged_d;
`ifdef DM_DISPLAY_EN
      $display("%d@%h: *%h <= %h", $time, bus.pc, {bus.addr[31:2], 2'b00}, merged_d);
`endif
    end
  end
`ifndef DM_DISPLAY_EN
  logic unused_pc;
  assign unused_pc = ^bus.pc;
`endif
  dm_load_ext u_ext (
    .raw_i   (raw),
    .lane_i  (bus.addr[1:0]),
    .sel_i   (bus.DMSel),
    .rdata_o (bus.rdata)
  );
endmodule

// File: tb/tb_dm_unit.sv
// tb_dm_unit: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_dm_unit;
  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic chk_v = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  exp_t sb_q[$];
  dm_unit_if bus();
  dm_unit dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  // monitor: whenever a response is flagged, pop the oldest expectation and compare
  always @(negedge clk) begin
    if (chk_v) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow got=%h", bus.rdata);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (bus.rdata !== e.exp) begin
          n_fail++;
          $display("FAIL %s got=%h exp=%h", e.name, bus.rdata, e.exp);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [31:0] a, input logic [2:0] s, input string nm, input logic [31:0] e);
    bus.addr = a;
    bus.DMSel = s;
    bus.DWE = 1'b0;
    sb_q.push_back('{nm, e});
    chk_v = 1'b1;
    tick();
    chk_v = 1'b0;
  endtask
  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s,
                    input logic chk, input string nm, input logic [31:0] old);
    bus.addr = a;
    bus.wdata = d;
    bus.DMSel = s;
    bus.DWE = 1'b1;
    if (chk) sb_q.push_back('{nm, old});
    chk_v = chk;
    tick();
    chk_v = 1'b0;
    bus.DWE = 1'b0;
  endtask
  initial begin
    bus.pc = 32'h0;
    bus.addr = 32'h0;
    bus.wdata = 32'h0;
    bus.DWE = 1'b0;
    bus.DMSel = 3'b000;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd(32'h0,    3'b000, "rst_0",    32'h0);
    rd(32'h4,    3'b000, "rst_4",    32'h0);
    rd(32'h2FFC, 3'b000, "rst_2ffc", 32'h0);
    st(32'h10, 32'h12345678, 3'b000, 1'b1, "sw_old_visible", 32'h0);
    st(32'h11, 32'h000000AB, 3'b010, 1'b0, "", 32'h0);
    st(32'h12, 32'h0000CDEF, 3'b001, 1'b0, "", 32'h0);
    rd(32'h10, 3'b000, "lw_merged",    32'hCDEFAB78);
    rd(32'h13, 3'b000, "lw_unaligned", 32'hCDEFAB78);
    rd(32'h11, 3'b010, "lb_11",        32'hFFFFFFAB);
    rd(32'h11, 3'b100, "lbu_11",       32'h000000AB);
    rd(32'h12, 3'b001, "lh_12",        32'hFFFFCDEF);
    rd(32'h12, 3'b011, "lhu_12",       32'h0000CDEF);
    rd(32'h10, 3'b010, "lb_10",        32'h00000078);
    rd(32'h13, 3'b010, "lb_13",        32'hFFFFFFCD);
    rd(32'h12, 3'b100, "lbu_12",       32'h000000EF);
    rd(32'h10, 3'b001, "lh_10",        32'hFFFFAB78);
    rd(32'h11, 3'b011, "lhu_11",       32'h0000AB78);
    rd(32'h10, 3'b101, "rsv_raw",      32'hCDEFAB78);
    st(32'h3000, 32'hDEADBEEF, 3'b000, 1'b1, "oor_store_rd", 32'h0);
    rd(32'h3000, 3'b000, "oor_rd",     32'h0);
    rd(32'h3000, 3'b101, "oor_rd_rsv", 32'h0);
    rd(32'h0,    3'b000, "oor_no_alias", 32'h0);
    rd(32'h10,   3'b000, "oor_no_change", 32'hCDEFAB78);
    st(32'h2FFC, 32'hA5A5A5A5, 3'b000, 1'b0, "", 32'h0);
    rd(32'h2FFC, 3'b000, "last_word",  32'hA5A5A5A5);
    st(32'h13, 32'h11223344, 3'b000, 1'b0, "", 32'h0);
    rd(32'h10, 3'b000, "sw_addr13",    32'h11223344);
    st(32'h11, 32'h0000BEEF, 3'b011, 1'b0, "", 32'h0);
    rd(32'h10, 3'b000, "shu_as_sh",    32'h1122BEEF);
    st(32'h13, 32'h00000077, 3'b100, 1'b0, "", 32'h0);
    rd(32'h10, 3'b000, "sbu_as_sb",    32'h7722BEEF);
    st(32'h10, 32'h00000000, 3'b110, 1'b0, "", 32'h0);
    rd(32'h10, 3'b000, "rsv_no_write", 32'h7722BEEF);
    bus.addr = 32'h20;
    bus.wdata = 32'hFFFFFFFF;
    bus.DMSel = 3'b000;
    bus.DWE = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.DWE = 1'b0;
    rd(32'h20,   3'b000, "rst_wins",   32'h0);
    rd(32'h10,   3'b000, "rst_clear",  32'h0);
    rd(32'h2FFC, 3'b000, "rst_clear_last", 32'h0);
    st(32'h20, 32'hFFFFFFFF, 3'b000, 1'b0, "", 32'h0);
    rd(32'h20, 3'b000, "sw_after_rst", 32'hFFFFFFFF);
    bus.pc = 32'h3000;
    st(32'h21, 32'h0000005A, 3'b010, 1'b1, "sb_old_visible", 32'hFFFFFFFF);
    rd(32'h20, 3'b000, "sb_21",        32'hFFFF5AFF);
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) tick();
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
